// File: rtl/tdm_demux4_if.sv
// Bundle for the TDM receive link: serial beat input side and the rebuilt
// parallel frame output side of tdm_demux4.
interface tdm_demux4_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             sof;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic             frame_valid;
   logic             locked;
   logic [1:0]       slot;
   logic             sync_err;

   modport master (
      output din, din_valid, sof,
      input  a, b, c, d, frame_valid, locked, slot, sync_err
   );

   modport slave (
      input  din, din_valid, sof,
      output a, b, c, d, frame_valid, locked, slot, sync_err
   );
endinterface

// File: rtl/tdm_demux4.sv
// Receive end of a 4-slot TDM byte link: collects slot 0..2 in shadow registers
// and publishes a..d together when the slot-3 beat arrives.
//
// state  | meaning
// HUNT   | not aligned; waiting for a valid beat with sof
// LOCKED | aligned; slot_q gives the slot expected for the next valid beat
module tdm_demux4 #(
   parameter int WIDTH = 8
) (
   input logic        clk,
   input logic        rst_n,
   tdm_demux4_if.slave bus
);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [1:0]       slot_q, slot_d;
   logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic             fv_q, fv_d;
   logic             serr_q, serr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         slot_q  <= 2'd0;
         s0_q    <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         fv_q    <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         fv_q    <= fv_d;
         serr_q  <= serr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.din_valid) begin
         unique case (state_q)
            HUNT:    if (bus.sof) state_d = LOCKED;
            LOCKED:  if (!bus.sof && slot_q == 2'd0) state_d = HUNT;
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      slot_d = slot_q;
      s0_d   = s0_q;
      s1_d   = s1_q;
      s2_d   = s2_q;
      a_d    = a_q;
      b_d    = b_q;
      c_d    = c_q;
      d_d    = d_q;
      fv_d   = 1'b0;
      serr_d = 1'b0;
      if (bus.din_valid) begin
         if (state_q == HUNT) begin
            if (bus.sof) begin
               s0_d   = bus.din;
               slot_d = 2'd1;
            end
         end else if (bus.sof) begin
            // Early sof drops the partial frame and restarts on this beat.
            serr_d = (slot_q != 2'd0);
            s0_d   = bus.din;
            slot_d = 2'd1;
         end else begin
            unique case (slot_q)
               2'd0: begin
                  serr_d = 1'b1;
                  slot_d = 2'd0;
               end
               2'd1: begin
                  s1_d   = bus.din;
                  slot_d = 2'd2;
               end
               2'd2: begin
                  s2_d   = bus.din;
                  slot_d = 2'd3;
               end
               default: begin
                  a_d    = s0_q;
                  b_d    = s1_q;
                  c_d    = s2_q;
                  d_d    = bus.din;
                  fv_d   = 1'b1;
                  slot_d = 2'd0;
               end
            endcase
         end
      end
   end

   assign bus.a           = a_q;
   assign bus.b           = b_q;
   assign bus.c           = c_q;
   assign bus.d           = d_q;
   assign bus.frame_valid = fv_q;
   assign bus.sync_err    = serr_q;
   assign bus.locked      = (state_q == LOCKED);
   assign bus.slot        = slot_q;

endmodule
